// File: rtl/hw_sw_comm_pkg.sv
// Shared state encoding and PIO signal codes for the software-to-hardware mailbox.
// Software-side codes (SIG_*) arrive on to_hw_sig; hardware-side codes (STS_*) drive to_sw_sig.
package hw_sw_comm_pkg;

    typedef enum logic [2:0] {
        ST_WAIT     = 3'd0,
        ST_READ_MSG = 3'd1,
        ST_ACK_MSG  = 3'd2,
        ST_BUSY     = 3'd3,
        ST_ERROR    = 3'd4
    } state_t;

    localparam logic [1:0] SIG_IDLE = 2'd0;
    localparam logic [1:0] SIG_ACK  = 2'd1;
    localparam logic [1:0] SIG_REQ  = 2'd2;
    localparam logic [1:0] SIG_BUSY = 2'd3;

    localparam logic [1:0] STS_IDLE = 2'd0;
    localparam logic [1:0] STS_ERR  = 2'd1;
    localparam logic [1:0] STS_CAPT = 2'd2;
    localparam logic [1:0] STS_BUSY = 2'd3;

    // ACK_MSG deliberately reports idle: software sees the ack as the status dropping back to 0.
    function automatic logic [1:0] sts_of(input state_t s);
        logic [1:0] code;
        code = STS_IDLE;
        case (s)
            ST_READ_MSG: code = STS_CAPT;
            ST_BUSY:     code = STS_BUSY;
            ST_ERROR:    code = STS_ERR;
            default:     code = STS_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/hw_sw_fifo.sv
// First-word fall-through FIFO; the pushed word is visible one cycle after the push edge.
// Pushes while full and pops while empty are ignored; pop_data reads 0 when empty.
module hw_sw_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        push_data,
    output logic [DATA_W-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    level_q, level_d;
    logic              do_push, do_pop;

    assign full    = (level_q == (PTR_W + 1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // DEPTH is a power of two, so the pointers wrap without any compare logic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
    assign level    = level_q;

endmodule

// File: rtl/hw_sw_mailbox.sv
// PIO handshake mailbox: one word per request/ack handshake into a FIFO, drained by a valid/ready stream; status 1 cycle after sampling.
// Full FIFO answers requests with BUSY; HW_SW_MAILBOX_TIMEOUT_EN adds a watchdog that parks a stalled handshake in ERROR.
module hw_sw_mailbox
    import hw_sw_comm_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               to_hw_sig,
    input  logic [DATA_W-1:0]        to_hw_data,
    output logic [1:0]               to_sw_sig,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         msg_count,
    output logic                     err
);
    state_t           state_q, state_d;
    logic             push;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    hw_sw_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (out_valid && out_ready),
        .push_data (to_hw_data),
        .pop_data  (out_data),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;

`ifdef HW_SW_MAILBOX_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             timed, expire;
    logic             err_q;

    assign timed  = (state_q == ST_READ_MSG) || (state_q == ST_ACK_MSG) || (state_q == ST_BUSY);
    assign expire = timed && (tmr_q == TMR_W'(TIMEOUT_CYC - 1));
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYC);
`endif

    // fifo_full is the registered level, so a same-cycle pop cannot rescue a request.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        if (to_hw_sig != SIG_BUSY) begin
            case (state_q)
                ST_WAIT, ST_BUSY: begin
                    if (to_hw_sig == SIG_REQ) begin
                        if (!fifo_full) begin
                            state_d = ST_READ_MSG;
                            push    = 1'b1;
                        end else begin
                            state_d = ST_BUSY;
                        end
                    end else if (to_hw_sig == SIG_IDLE && state_q == ST_BUSY) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_READ_MSG: if (to_hw_sig == SIG_ACK)  state_d = ST_ACK_MSG;
                ST_ACK_MSG:  if (to_hw_sig == SIG_IDLE) state_d = ST_WAIT;
                ST_ERROR:    if (to_hw_sig == SIG_IDLE) state_d = ST_WAIT;
                default:     state_d = ST_WAIT;
            endcase
        end
`ifdef HW_SW_MAILBOX_TIMEOUT_EN
        if (expire && state_d == state_q) state_d = ST_ERROR;
`endif
    end

    assign cnt_d = push ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HW_SW_MAILBOX_TIMEOUT_EN
    assign tmr_d = (state_d != state_q || !timed) ? '0 : tmr_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            err_q <= err_q || (state_d == ST_ERROR);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign to_sw_sig = sts_of(state_q);
    assign msg_count = cnt_q;

endmodule

// File: tb/tb_hw_sw_mailbox.sv
// Directed bench for hw_sw_mailbox with a queue-based reference model checked every cycle.
module tb_hw_sw_mailbox;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 4;
    localparam int TO_CYC = 16;

    localparam int P_WAIT = 0, P_READ = 1, P_ACK = 2, P_BUSY = 3, P_ERR = 4;

    logic              clk, reset;
    logic [1:0]        to_hw_sig;
    logic [DATA_W-1:0] to_hw_data;
    logic [1:0]        to_sw_sig;
    logic [DATA_W-1:0] out_data;
    logic              out_valid, out_ready;
    logic [2:0]        fifo_level;
    logic [CNT_W-1:0]  msg_count;
    logic              err;

    int total = 0;
    int bad   = 0;

    // reference model
    int                m_phase = P_WAIT;
    int                m_nxt;
    int                m_stay = 0;
    int                m_cnt = 0;
    bit                m_err = 0;
    bit                m_push, m_full;
    logic [DATA_W-1:0] m_q [$];
    int                exp_sts [5] = '{0, 2, 0, 3, 1};

    hw_sw_mailbox #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .to_hw_sig  (to_hw_sig),
        .to_hw_data (to_hw_data),
        .to_sw_sig  (to_sw_sig),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .msg_count  (msg_count),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by %0t, required finish", $time);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic handshake(input logic [DATA_W-1:0] d);
        to_hw_data = d;
        to_hw_sig  = 2'd2;
        tick(1);
        to_hw_sig  = 2'd1;
        tick(1);
        to_hw_sig  = 2'd0;
        tick(1);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_sts"},   64'(to_sw_sig),  64'd0);
        chk({nm, "_valid"}, 64'(out_valid),  64'd0);
        chk({nm, "_data"},  64'(out_data),   64'd0);
        chk({nm, "_level"}, 64'(fifo_level), 64'd0);
        chk({nm, "_count"}, 64'(msg_count),  64'd0);
        chk({nm, "_err"},   64'(err),        64'd0);
    endtask

    // Model: the handshake as phases, the FIFO as a queue, the watchdog as time-in-phase.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = P_WAIT;
            m_q.delete();
            m_cnt   = 0;
            m_err   = 0;
            m_stay  = 0;
        end else begin
            m_full = (m_q.size() == DEPTH);
            m_nxt  = m_phase;
            m_push = 0;
            if (to_hw_sig == 2'd2 && (m_phase == P_WAIT || m_phase == P_BUSY)) begin
                if (!m_full) begin
                    m_nxt  = P_READ;
                    m_push = 1;
                end else begin
                    m_nxt = P_BUSY;
                end
            end else if (to_hw_sig == 2'd1 && m_phase == P_READ) begin
                m_nxt = P_ACK;
            end else if (to_hw_sig == 2'd0 && (m_phase == P_ACK || m_phase == P_BUSY || m_phase == P_ERR)) begin
                m_nxt = P_WAIT;
            end
`ifdef HW_SW_MAILBOX_TIMEOUT_EN
            if (m_nxt == m_phase && (m_phase == P_READ || m_phase == P_ACK || m_phase == P_BUSY)
                && m_stay == TO_CYC) begin
                m_nxt = P_ERR;
                m_err = 1;
            end
`endif
            if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
            if (m_push) begin
                m_q.push_back(to_hw_data);
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end
            m_stay  = (m_nxt != m_phase) ? 1 : m_stay + 1;
            m_phase = m_nxt;
        end
    end

    always @(negedge clk) begin
        chk("m_sts",   64'(to_sw_sig),  64'(exp_sts[m_phase]));
        chk("m_valid", 64'(out_valid),  64'(m_q.size() > 0));
        chk("m_data",  64'(out_data),   (m_q.size() > 0) ? 64'(m_q[0]) : 64'd0);
        chk("m_level", 64'(fifo_level), 64'(m_q.size()));
        chk("m_count", 64'(msg_count),  64'(m_cnt));
        chk("m_err",   64'(err),        64'(m_err));
    end

    initial begin
        reset      = 1'b1;
        to_hw_sig  = 2'd0;
        to_hw_data = '0;
        out_ready  = 1'b0;
        #1 reset = 1'b0;
        #3 chk_reset_vals("rst");
        tick(2);
        reset = 1'b1;
        tick(1);

        // single word
        to_hw_data = 32'hDEADBEEF;
        to_hw_sig  = 2'd2;
        tick(1);
        chk("one_sts",   64'(to_sw_sig), 64'd2);
        chk("one_valid", 64'(out_valid), 64'd1);
        chk("one_data",  64'(out_data),  64'hDEADBEEF);
        chk("one_count", 64'(msg_count), 64'd1);
        to_hw_sig = 2'd1;
        tick(1);
        chk("one_ack", 64'(to_sw_sig), 64'd0);
        to_hw_sig = 2'd0;
        tick(1);
        chk("one_idle", 64'(to_sw_sig), 64'd0);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("one_drained", 64'(fifo_level), 64'd0);

        // reserved code in WAIT
        to_hw_sig = 2'd3;
        tick(2);
        chk("rsvd_sts",   64'(to_sw_sig),  64'd0);
        chk("rsvd_level", 64'(fifo_level), 64'd0);
        to_hw_sig = 2'd0;
        tick(1);

        // fill, busy, then one pop frees a slot for the following request
        for (int i = 0; i < 4; i++) handshake(32'h10 + i);
        chk("fill_level", 64'(fifo_level), 64'd4);
        chk("fill_count", 64'(msg_count),  64'd5);
        to_hw_data = 32'h14;
        to_hw_sig  = 2'd2;
        tick(1);
        chk("busy_sts",   64'(to_sw_sig),  64'd3);
        chk("busy_level", 64'(fifo_level), 64'd4);
        chk("busy_count", 64'(msg_count),  64'd5);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("pop_same_sts",   64'(to_sw_sig),  64'd3);
        chk("pop_same_level", 64'(fifo_level), 64'd3);
        tick(1);
        chk("refill_sts",   64'(to_sw_sig),  64'd2);
        chk("refill_level", 64'(fifo_level), 64'd4);
        chk("refill_count", 64'(msg_count),  64'd6);
        to_hw_sig = 2'd1;
        tick(1);
        to_hw_sig = 2'd0;
        tick(1);

        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", 64'(out_data), 64'h11 + 64'(i));
            tick(1);
        end
        chk("drain_empty", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // order plus simultaneous push and pop
        handshake(32'd1);
        handshake(32'd2);
        handshake(32'd3);
        chk("ord_level", 64'(fifo_level), 64'd3);
        chk("ord_head",  64'(out_data),   64'd1);
        out_ready  = 1'b1;
        to_hw_data = 32'd4;
        to_hw_sig  = 2'd2;
        tick(1);
        chk("pp_level", 64'(fifo_level), 64'd3);
        chk("pp_head",  64'(out_data),   64'd2);
        to_hw_sig = 2'd1;
        tick(1);
        chk("ord_d3", 64'(out_data), 64'd3);
        to_hw_sig = 2'd0;
        tick(1);
        chk("ord_d4", 64'(out_data), 64'd4);
        tick(1);
        chk("ord_empty", 64'(out_valid), 64'd0);
        chk("ord_count", 64'(msg_count), 64'd10);
        out_ready = 1'b0;

        // asynchronous reset in READ_MSG with two words held
        handshake(32'hA1);
        to_hw_data = 32'hA2;
        to_hw_sig  = 2'd2;
        tick(1);
        chk("pre_rst_sts",   64'(to_sw_sig),  64'd2);
        chk("pre_rst_level", 64'(fifo_level), 64'd2);
        reset = 1'b0;
        #1 chk_reset_vals("arst");
        to_hw_sig = 2'd0;
        tick(2);
        reset = 1'b1;
        tick(1);

        // counter wrap with CNT_W=4
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) handshake(32'h100 + i);
        chk("wrap16", 64'(msg_count), 64'd0);
        handshake(32'h200);
        chk("wrap17", 64'(msg_count), 64'd1);
        out_ready = 1'b0;

        // request held without ack
        to_hw_data = 32'hCAFE;
        to_hw_sig  = 2'd2;
        tick(1);
        chk("hold_enter", 64'(to_sw_sig), 64'd2);
        tick(15);
        chk("hold_15", 64'(to_sw_sig), 64'd2);
        tick(1);
`ifdef HW_SW_MAILBOX_TIMEOUT_EN
        chk("to_sts", 64'(to_sw_sig), 64'd1);
        chk("to_err", 64'(err),       64'd1);
        to_hw_sig = 2'd0;
        tick(1);
        chk("to_wait_sts", 64'(to_sw_sig), 64'd0);
        chk("to_err_hold", 64'(err),       64'd1);
        chk("to_word_kept", 64'(out_data), 64'hCAFE);
`else
        chk("noto_sts", 64'(to_sw_sig), 64'd2);
        chk("noto_err", 64'(err),       64'd0);
        to_hw_sig = 2'd0;
        tick(40);
        chk("noto_long", 64'(to_sw_sig), 64'd2);
        to_hw_sig = 2'd1;
        tick(1);
        to_hw_sig = 2'd0;
        tick(1);
        chk("noto_done", 64'(to_sw_sig), 64'd0);
`endif
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hw_sw_mailbox.md
# hw_sw_mailbox

Parametrised successor to the two-bit hardware/software handshake block. It captures data words that software posts over the PIO handshake into an internal FIFO, and presents them to game logic through a valid/ready stream. Relative to the earlier block it adds a data path, backpressure signalling when the FIFO is full, a message counter, and an optional handshake-timeout watchdog. It sits between the NIOS PIO registers and the game-logic command consumer, in the same clock domain as the PIO.

## Interface
- DATA_W, 32, width of one message word
- DEPTH, 4, FIFO depth in words; must be a power of two, ≥ 2
- CNT_W, 16, width of the accepted-message counter
- TIMEOUT_CYC, 1024, watchdog limit in cycles; used only when the timeout feature is compiled in
- clk  in  1  system clock, all logic on the rising edge
- reset  in  1  asynchronous, active-low; the port keeps the codebase name `reset`
- to_hw_sig  in  2  software command: 0 = idle, 2 = request (data valid), 1 = acknowledge, 3 = reserved
- to_hw_data  in  DATA_W  message word; sampled only on the request edge
- to_sw_sig  out  2  hardware status: 0 = idle/ack, 2 = word captured, 3 = busy (FIFO full), 1 = timeout error
- out_data  out  DATA_W  FIFO head word (first-word fall-through)
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer pops the head word when out_valid && out_ready
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy
- msg_count  out  CNT_W  number of accepted words; wraps modulo 2^CNT_W
- err  out  1  sticky timeout flag

## Operation
- States: WAIT, READ_MSG, ACK_MSG, BUSY, and ERROR (ERROR exists only with the timeout feature).
- to_sw_sig is a Moore output decoded from the state: WAIT → 0, READ_MSG → 2, ACK_MSG → 0, BUSY → 3, ERROR → 1.
- WAIT:
  - to_hw_sig==2 and FIFO not full → READ_MSG; push to_hw_data and increment msg_count on the same edge.
  - to_hw_sig==2 and FIFO full → BUSY; no push.
- BUSY:
  - to_hw_sig==2 and FIFO not full → READ_MSG with push and count increment.
  - to_hw_sig==0 → WAIT.
- READ_MSG: to_hw_sig==1 → ACK_MSG.
- ACK_MSG: to_hw_sig==0 → WAIT.
- ERROR: to_hw_sig==0 → WAIT.
- A value of 3 on to_hw_sig, or any code not listed for the current state, holds the state. Exactly one word is pushed per handshake.
- Full is evaluated from the registered fifo_level. A pop in the same cycle does not free a slot for a request sampled in that cycle; that request enters BUSY.
- FIFO push and pop in the same cycle on a non-full, non-empty FIFO: level is unchanged and both pointers advance.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally.

## Timing
- Reset (asynchronous assert, synchronous release): state = WAIT, to_sw_sig = 0, out_valid = 0, out_data = 0, fifo_level = 0, msg_count = 0, err = 0, pointers = 0.
- Reset asserted mid-handshake aborts it immediately and discards FIFO contents.
- to_sw_sig responds 1 cycle after to_hw_sig is sampled.
- A pushed word appears on out_valid/out_data 1 cycle after the push edge.
- Pop takes effect at the edge where out_valid && out_ready; the next word is presented in the following cycle.

## Configuration
- Macro: HW_SW_MAILBOX_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on every state change.
  - If the block remains in READ_MSG, ACK_MSG or BUSY for TIMEOUT_CYC consecutive cycles, it enters ERROR and sets err.
  - err stays set until reset.
  - A word already pushed stays in the FIFO.
- Undefined: no counter and no ERROR state; err is tied to 0 and TIMEOUT_CYC is ignored.

## Structure
- Package hw_sw_comm_pkg holds:
  - the state enum;
  - signal-code localparams: SIG_IDLE=0, SIG_ACK=1, SIG_REQ=2, SIG_BUSY=3 for to_hw_sig, and STS_IDLE, STS_ERR, STS_CAPT, STS_BUSY for to_sw_sig.
- One sub-module, hw_sw_fifo (parameters DATA_W, DEPTH), provides push, pop, data, level, full and empty.
- The handshake FSM, counter and watchdog live in hw_sw_mailbox.

## Test plan
- Single word: to_hw_data=32'hDEADBEEF, to_hw_sig=2 → next cycle to_sw_sig=2, out_valid=1, out_data=DEADBEEF, msg_count=1. Then sig=1 → to_sw_sig=0; sig=0 → WAIT.
- Fill: DEPTH=4, out_ready=0, four complete handshakes → fifo_level=4. Fifth request → to_sw_sig=3 and no push. Pulse out_ready once → the next sampled request enters READ_MSG, pushes, and fifo_level returns to 4.
- Order: push 1, 2, 3, then drain with out_ready=1 → out_data sequence 1, 2, 3, and out_valid=0 afterwards. Simultaneous push and pop keep the level constant.
- Timeout (macro on, TIMEOUT_CYC=16): hold sig=2 → 16 cycles after entering READ_MSG, to_sw_sig=1 and err=1. Then sig=0 → WAIT, err stays 1. With the macro off → block stays in READ_MSG indefinitely.
- Reset mid-op: assert reset in READ_MSG with fifo_level=2 → all outputs return to reset values without waiting for a clock edge.
- Reserved and wrap: to_hw_sig=3 in WAIT → no state change. With CNT_W=4, 17 handshakes → msg_count=1.
